// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain sequencer.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_e;

  localparam int SCAN_N_DEFAULT = 4;

  localparam logic SCAN_SHIFT = 1'b1;
  localparam logic SCAN_LOAD  = 1'b0;

endpackage

// File: rtl/scan_ctrl_if.sv
// Host-side handshake plus scan chain pins for one scan_ctrl instance.
interface scan_ctrl_if #(
  parameter int N = 4
);

  logic         start;
  logic [N-1:0] pattern;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         scan_test;
  logic         scan_sin;
  logic         scan_sout;

  modport master (
    output start, pattern, scan_sout,
    input  busy, done, result, scan_test, scan_sin
  );

  modport slave (
    input  start, pattern, scan_sout,
    output busy, done, result, scan_test, scan_sin
  );

endinterface

// File: rtl/scan_bitcnt.sv
// Loadable down-counter with zero flag; paces both shift phases of the sequencer.
module scan_bitcnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_loadVal,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/scan_ctrl.sv
// Scan cycle sequencer: shifts a pattern in, captures once, then shifts the
// captured word out into result.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int N  = SCAN_N_DEFAULT,
  parameter int CW = $clog2(N + 1)
) (
  input  logic       clk,
  input  logic       rst,
  scan_ctrl_if.slave bus
);

  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  scan_state_e   r_state;
  scan_state_e   w_nextState;
  logic [N-1:0]  r_pattern;
  logic [N-1:0]  r_result;
  logic          w_cntLoad;
  logic          w_cntDec;
  logic [CW-1:0] w_count;
  logic          w_cntZero;

  scan_bitcnt #(
    .CW(CW)
  ) u_bitcnt (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_cntLoad),
    .i_loadVal(LAST_BIT),
    .i_dec    (w_cntDec),
    .o_count  (w_count),
    .o_zero   (w_cntZero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The pattern is frozen at acceptance so later host changes cannot corrupt the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_pattern <= bus.pattern;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (r_state == SHIFT_OUT) begin
      r_result <= {r_result[N-2:0], bus.scan_sout};
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_cntLoad     = 1'b0;
    w_cntDec      = 1'b0;
    bus.scan_test = SCAN_LOAD;
    bus.scan_sin  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_cntLoad   = 1'b1;
          w_nextState = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        bus.scan_test = SCAN_SHIFT;
        bus.scan_sin  = r_pattern[w_count];
        bus.busy      = 1'b1;
        w_cntDec      = 1'b1;
        if (w_cntZero) begin
          w_nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        bus.busy    = 1'b1;
        w_cntLoad   = 1'b1;
        w_nextState = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        bus.scan_test = SCAN_SHIFT;
        bus.busy      = 1'b1;
        w_cntDec      = 1'b1;
        if (w_cntZero) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        bus.done    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign bus.result = r_result;

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl: behavioural scan registers for N=4 and N=8,
// directed scan cycles, and a done-driven monitor checking result and latency.
module tb_scan_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  scan_ctrl_if #(.N(4)) busA ();
  scan_ctrl_if #(.N(8)) busB ();

  scan_ctrl #(.N(4)) dutA (.clk(clk), .rst(rst), .bus(busA.slave));
  scan_ctrl #(.N(8)) dutB (.clk(clk), .rst(rst), .bus(busB.slave));

  logic [3:0] chainA = '0;
  logic [3:0] dataA  = '0;
  logic [7:0] chainB = '0;
  logic [7:0] dataB  = '0;

  // Behavioural scan registers: shift on test=1, parallel load otherwise.
  always @(posedge clk) begin
    chainA <= busA.scan_test ? {chainA[2:0], busA.scan_sin} : dataA;
    chainB <= busB.scan_test ? {chainB[6:0], busB.scan_sin} : dataB;
  end

  assign busA.scan_sout = chainA[3];
  assign busB.scan_sout = chainB[7];

  int cycNow = 0;
  always @(posedge clk) cycNow <= cycNow + 1;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       sin;
    logic       test;
    logic       busy;
    logic       done;
    logic [7:0] chain;
    logic [7:0] result;
  } obs_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA;
  exp_t eB;

  int vecCount  = 0;
  int missCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycNow);
    end
  endtask

  function automatic obs_t getObs(input bit which);
    obs_t o;
    if (which) begin
      o.sin    = busB.scan_sin;
      o.test   = busB.scan_test;
      o.busy   = busB.busy;
      o.done   = busB.done;
      o.chain  = chainB;
      o.result = busB.result;
    end else begin
      o.sin    = busA.scan_sin;
      o.test   = busA.scan_test;
      o.busy   = busA.busy;
      o.done   = busA.done;
      o.chain  = {4'b0, chainA};
      o.result = {4'b0, busA.result};
    end
    return o;
  endfunction

  task automatic setStart(input bit which, input logic v);
    if (which) busB.start = v;
    else       busA.start = v;
  endtask

  task automatic setPattern(input bit which, input logic [7:0] p);
    if (which) busB.pattern = p;
    else       busA.pattern = p[3:0];
  endtask

  task automatic setData(input bit which, input logic [7:0] d);
    if (which) dataB = d;
    else       dataA = d[3:0];
  endtask

  // Entered at the negedge of an IDLE cycle (cycle 0); returns at the negedge of the DONE cycle.
  task automatic applyStimulus(input bit which, input logic [7:0] pat, input logic [7:0] data,
                               input bit changePat, input logic [7:0] altPat, input bit extraStart);
    int   n;
    int   c0;
    exp_t e;
    obs_t o;
    logic expSin;
    logic expTest;
    logic expBusy;
    n  = which ? 8 : 4;
    c0 = cycNow;
    setPattern(which, pat);
    setData(which, data);
    setStart(which, 1'b1);
    e.res = data;
    e.cyc = c0 + 2 * n + 2;
    if (which) qB.push_back(e);
    else       qA.push_back(e);
    for (int k = 1; k <= 2 * n + 2; k++) begin
      @(negedge clk);
      setStart(which, extraStart && ((k == 3) || (k == 2 * n + 2)));
      if (changePat && (k == 2)) setPattern(which, altPat);
      o       = getObs(which);
      expSin  = (k <= n) ? pat[n - k] : 1'b0;
      expTest = (k <= n) || ((k >= n + 2) && (k <= 2 * n + 1));
      expBusy = (k <= 2 * n + 1);
      checkOutput($sformatf("scan_sin[k=%0d]", k), 32'(o.sin), 32'(expSin));
      checkOutput($sformatf("scan_test[k=%0d]", k), 32'(o.test), 32'(expTest));
      checkOutput($sformatf("busy[k=%0d]", k), 32'(o.busy), 32'(expBusy));
      if (k == n + 1) checkOutput("chainAfterShiftIn", 32'(o.chain), 32'(pat));
      if (k == 2 * n + 2) checkOutput("chainFlushed", 32'(o.chain), 32'(0));
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (busA.done === 1'b1) begin
      if (qA.size() == 0) begin
        checkOutput("unexpectedDoneA", 32'(1), 32'(0));
      end else begin
        eA = qA.pop_front();
        checkOutput("resultA", 32'(busA.result), 32'(eA.res));
        checkOutput("doneCycleA", 32'(cycNow), 32'(eA.cyc));
      end
    end
    if (busB.done === 1'b1) begin
      if (qB.size() == 0) begin
        checkOutput("unexpectedDoneB", 32'(1), 32'(0));
      end else begin
        eB = qB.pop_front();
        checkOutput("resultB", 32'(busB.result), 32'(eB.res));
        checkOutput("doneCycleB", 32'(cycNow), 32'(eB.cyc));
      end
    end
  end

  initial begin
    obs_t o;
    rst          = 1'b1;
    busA.start   = 1'b0;
    busA.pattern = '0;
    busB.start   = 1'b0;
    busB.pattern = '0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      o = getObs(w[0]);
      checkOutput("resetBusy", 32'(o.busy), 32'(0));
      checkOutput("resetDone", 32'(o.done), 32'(0));
      checkOutput("resetResult", 32'(o.result), 32'(0));
      checkOutput("resetTest", 32'(o.test), 32'(0));
      checkOutput("resetSin", 32'(o.sin), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic cycle, pattern 1010, data 0011");
    applyStimulus(1'b0, 8'h0A, 8'h03, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    $display("[TB] capture ignores pattern, pattern 1111, data 1100");
    applyStimulus(1'b0, 8'h0F, 8'h0C, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    $display("[TB] start while busy and in DONE ignored, then restart");
    applyStimulus(1'b0, 8'h06, 8'h09, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h03, 8'h06, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    $display("[TB] reset mid shift-in");
    busA.pattern = 4'hA;
    dataA        = 4'h5;
    busA.start   = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o   = getObs(1'b0);
    checkOutput("midResetBusy", 32'(o.busy), 32'(0));
    checkOutput("midResetTest", 32'(o.test), 32'(0));
    checkOutput("midResetSin", 32'(o.sin), 32'(0));
    checkOutput("midResetResult", 32'(o.result), 32'(0));
    checkOutput("midResetDone", 32'(o.done), 32'(0));
    busA.start = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    rst        = 1'b0;
    o          = getObs(1'b0);
    checkOutput("resetBeatsStart", 32'(o.busy), 32'(0));
    repeat (12) @(negedge clk);
    o = getObs(1'b0);
    checkOutput("idleAfterReset", 32'(o.busy), 32'(0));
    applyStimulus(1'b0, 8'h0A, 8'h05, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    $display("[TB] pattern change after acceptance");
    applyStimulus(1'b0, 8'h0A, 8'h09, 1'b1, 8'h05, 1'b0);
    @(negedge clk);

    $display("[TB] N=8, pattern 3C, data A5");
    applyStimulus(1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    checkOutput("pendingA", 32'(qA.size()), 32'(0));
    checkOutput("pendingB", 32'(qB.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
